// File: rtl/flag_stack_reg.sv
// flag_stack_reg: parametrised CPU status-flag register with save/restore LIFO.
// Each flag is either level (follows the ALU) or sticky (OR-accumulates until
// cleared). A register-array stack of STACK_DEPTH entries saves and restores
// the flag word for interrupt/call context, with full/empty status and a
// sticky error flag for overflow, underflow and push+pop collisions.
// Optional feature macro: FLAG_PUSH_AUTOCLR_EN. When defined, a successful
// push also zeroes flag_out so the handler starts with clean flags.
module flag_stack_reg #(
   parameter int                FLAG_W      = 4,
   parameter int                STACK_DEPTH = 4,
   parameter logic [FLAG_W-1:0] STICKY_MASK = 4'b0101,
   parameter int                LVL_W       = 3
) (
   input  logic              clk,
   input  logic              flag_rst_n,
   input  logic              flag_we,
   input  logic [FLAG_W-1:0] flag_mask,
   input  logic [FLAG_W-1:0] flag_in,
   input  logic [FLAG_W-1:0] flag_clr,
   input  logic              flag_push,
   input  logic              flag_pop,
   input  logic              err_clr,
   output logic [FLAG_W-1:0] flag_out,
   output logic              stk_full,
   output logic              stk_empty,
   output logic [LVL_W-1:0]  stk_level,
   output logic              stk_err
);

   logic [FLAG_W-1:0] r_stack [STACK_DEPTH];
   logic [FLAG_W-1:0] r_flags;
   logic [LVL_W-1:0]  r_level;
   logic              r_err;

   logic              w_full;
   logic              w_empty;
   logic              w_push_ok;
   logic              w_pop_ok;
   logic              w_err_set;
   logic [LVL_W-1:0]  w_top_idx;
   logic [FLAG_W-1:0] w_top;
   logic [FLAG_W-1:0] w_flag_upd;
   logic [FLAG_W-1:0] w_flag_nxt;

   assign w_full    = (r_level == LVL_W'(STACK_DEPTH));
   assign w_empty   = (r_level == '0);
   // A simultaneous push and pop performs no stack operation at all.
   assign w_push_ok = flag_push && !flag_pop && !w_full;
   assign w_pop_ok  = flag_pop && !flag_push && !w_empty;
   assign w_err_set = (flag_push && flag_pop)
                    || (flag_push && !flag_pop && w_full)
                    || (flag_pop && !flag_push && w_empty);
   assign w_top_idx = r_level - LVL_W'(1);

   // Read the stack top by compare-select so an empty stack never indexes out of range.
   always_comb begin
      w_top = '0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
         if (w_top_idx == LVL_W'(i)) w_top = r_stack[i];
      end
   end

   // Per-bit ALU update: clear beats set, sticky bits OR-accumulate, level bits follow.
   always_comb begin
      w_flag_upd = r_flags;
      for (int i = 0; i < FLAG_W; i++) begin
         if (flag_clr[i]) begin
            w_flag_upd[i] = 1'b0;
         end else if (flag_we && flag_mask[i]) begin
            w_flag_upd[i] = STICKY_MASK[i] ? (r_flags[i] | flag_in[i]) : flag_in[i];
         end
      end
   end

   // Next flag word: a successful pop restores and overrides the ALU update.
   always_comb begin
      w_flag_nxt = w_flag_upd;
      if (w_pop_ok) begin
         w_flag_nxt = w_top;
      end
`ifdef FLAG_PUSH_AUTOCLR_EN
      else if (w_push_ok) begin
         w_flag_nxt = '0;
      end
`endif
   end

   // Flag word, stack level and sticky error state; reset has top priority.
   always_ff @(posedge clk) begin
      if (!flag_rst_n) begin
         r_flags <= '0;
         r_level <= '0;
         r_err   <= 1'b0;
      end else begin
         r_flags <= w_flag_nxt;
         if (w_push_ok)     r_level <= r_level + LVL_W'(1);
         else if (w_pop_ok) r_level <= r_level - LVL_W'(1);
         if (w_err_set)     r_err <= 1'b1;
         else if (err_clr)  r_err <= 1'b0;
      end
   end

   // Stack storage saves the pre-update flag word; contents are not reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
         if (flag_rst_n && w_push_ok && (r_level == LVL_W'(i))) r_stack[i] <= r_flags;
      end
   end

   assign flag_out  = r_flags;
   assign stk_level = r_level;
   assign stk_err   = r_err;
   assign stk_full  = w_full;
   assign stk_empty = w_empty;

endmodule

// File: tb/tb_flag_stack_reg.sv
// tb_flag_stack_reg: directed vectors with hand-computed expectations for
// flag_stack_reg (FLAG_W=4, STACK_DEPTH=4, STICKY_MASK=4'b0101: C and B sticky).
module tb_flag_stack_reg;

   logic       clk = 1'b0;
   logic       flag_rst_n;
   logic       flag_we;
   logic [3:0] flag_mask;
   logic [3:0] flag_in;
   logic [3:0] flag_clr;
   logic       flag_push;
   logic       flag_pop;
   logic       err_clr;
   logic [3:0] flag_out;
   logic       stk_full;
   logic       stk_empty;
   logic [2:0] stk_level;
   logic       stk_err;

   int n_chk = 0;
   int n_err = 0;

   flag_stack_reg #(
      .FLAG_W(4), .STACK_DEPTH(4), .STICKY_MASK(4'b0101), .LVL_W(3)
   ) dut (
      .clk(clk), .flag_rst_n(flag_rst_n), .flag_we(flag_we), .flag_mask(flag_mask),
      .flag_in(flag_in), .flag_clr(flag_clr), .flag_push(flag_push), .flag_pop(flag_pop),
      .err_clr(err_clr), .flag_out(flag_out), .stk_full(stk_full), .stk_empty(stk_empty),
      .stk_level(stk_level), .stk_err(stk_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      flag_we = 1'b0; flag_mask = 4'h0; flag_in = 4'h0; flag_clr = 4'h0;
      flag_push = 1'b0; flag_pop = 1'b0; err_clr = 1'b0;
   endtask

   // Inputs change 1 time unit after a rising edge; outputs are read there too.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Load an exact flag word in one cycle: clear the zero bits, write the ones.
   task automatic setv(input logic [3:0] v);
      flag_clr = ~v; flag_we = 1'b1; flag_mask = 4'hF; flag_in = v;
      step();
      idle();
   endtask

   task automatic push1();
      flag_push = 1'b1; step(); idle();
   endtask

   task automatic pop1();
      flag_pop = 1'b1; step(); idle();
   endtask

   initial begin
      idle();
      flag_rst_n = 1'b0;

      // 1: reset, level and sticky behaviour
      step(); step();
      chk("rst_out",   8'(flag_out), 8'h0);
      chk("rst_empty", 8'(stk_empty), 8'h1);
      chk("rst_full",  8'(stk_full), 8'h0);
      chk("rst_level", 8'(stk_level), 8'h0);
      chk("rst_err",   8'(stk_err), 8'h0);
      flag_rst_n = 1'b1;
      flag_we = 1'b1; flag_mask = 4'hF; flag_in = 4'b0001; step();
      chk("c_set", 8'(flag_out), 8'h1);
      flag_in = 4'b0000; step();
      chk("c_sticky", 8'(flag_out), 8'h1);
      idle(); flag_clr = 4'b0001; step(); idle();
      chk("c_clr", 8'(flag_out), 8'h0);

      // 2: level flag follows, clear wins over set
      flag_we = 1'b1; flag_mask = 4'hF; flag_in = 4'b0010; step();
      chk("z_set", 8'(flag_out), 8'h2);
      flag_in = 4'b0000; step();
      chk("z_follow", 8'(flag_out), 8'h0);
      flag_in = 4'b0100; flag_clr = 4'b0100; step(); idle();
      chk("b_clr_wins", 8'(flag_out), 8'h0);

      // 3: write mask
      setv(4'b1010);
      chk("setv_a", 8'(flag_out), 8'hA);
      flag_we = 1'b1; flag_mask = 4'b0010; flag_in = 4'b0000; step(); idle();
      chk("mask", 8'(flag_out), 8'h8);
      flag_mask = 4'b0000; flag_in = 4'hF; step(); idle();
      chk("we_low", 8'(flag_out), 8'h8);

      // 4: push to full, overflow, pops restore in LIFO order
      setv(4'hA); push1();
      chk("lvl1", 8'(stk_level), 8'h1);
      setv(4'h5); push1();
      setv(4'h3); push1();
      setv(4'hC); push1();
      chk("full", 8'(stk_full), 8'h1);
      chk("lvl4", 8'(stk_level), 8'h4);
      chk("no_err_yet", 8'(stk_err), 8'h0);
      push1();
      chk("ovf_err", 8'(stk_err), 8'h1);
      chk("ovf_lvl", 8'(stk_level), 8'h4);
      err_clr = 1'b1; step(); idle();
      chk("err_clr", 8'(stk_err), 8'h0);
      // first pop also drives we/clr, which must be ignored
      flag_pop = 1'b1; flag_we = 1'b1; flag_mask = 4'hF; flag_in = 4'hF; flag_clr = 4'hF;
      step(); idle();
      chk("pop_c", 8'(flag_out), 8'hC);
      pop1();
      chk("pop_3", 8'(flag_out), 8'h3);
      pop1();
      chk("pop_5", 8'(flag_out), 8'h5);
      pop1();
      chk("pop_a", 8'(flag_out), 8'hA);
      chk("empty", 8'(stk_empty), 8'h1);
      chk("pop_no_err", 8'(stk_err), 8'h0);
      pop1();
      chk("unf_out", 8'(flag_out), 8'hA);
      chk("unf_err", 8'(stk_err), 8'h1);
      chk("unf_lvl", 8'(stk_level), 8'h0);

      // 5: collision and error clear
      err_clr = 1'b1; step(); idle();
      chk("err_clr2", 8'(stk_err), 8'h0);
      setv(4'b0001); push1(); push1();
      chk("lvl2", 8'(stk_level), 8'h2);
      flag_push = 1'b1; flag_pop = 1'b1; flag_we = 1'b1; flag_mask = 4'b0010; flag_in = 4'b0010;
      step(); idle();
      chk("col_lvl", 8'(stk_level), 8'h2);
      chk("col_err", 8'(stk_err), 8'h1);
      chk("col_upd", 8'(flag_out), 8'h3);
      err_clr = 1'b1; step(); idle();
      chk("err_clr3", 8'(stk_err), 8'h0);
      pop1(); pop1();
      chk("pop_to_empty", 8'(stk_empty), 8'h1);
      chk("pop_restore", 8'(flag_out), 8'h1);
      flag_pop = 1'b1; err_clr = 1'b1; step(); idle();
      chk("set_beats_clr", 8'(stk_err), 8'h1);

      // 6: reset mid-operation, then the optional push auto-clear
      setv(4'h7); push1(); push1(); push1();
      chk("lvl3", 8'(stk_level), 8'h3);
      flag_rst_n = 1'b0; flag_pop = 1'b1; step(); idle();
      chk("mrst_out", 8'(flag_out), 8'h0);
      chk("mrst_lvl", 8'(stk_level), 8'h0);
      chk("mrst_err", 8'(stk_err), 8'h0);
      chk("mrst_empty", 8'(stk_empty), 8'h1);
      flag_rst_n = 1'b1;
      setv(4'hF); push1();
      chk("ac_lvl", 8'(stk_level), 8'h1);
`ifdef FLAG_PUSH_AUTOCLR_EN
      chk("ac_out", 8'(flag_out), 8'h0);
`else
      chk("ac_out", 8'(flag_out), 8'hF);
`endif
      setv(4'h2); pop1();
      chk("ac_top", 8'(flag_out), 8'hF);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   // Hard time bound so the run can never hang.
   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete, expected finish");
      $fatal(1);
   end

endmodule

// File: doc/flag_stack_reg.md
Name: flag_stack_reg

Overview:
Parametrised CPU status-flag register, successor to the fixed 3-flag C/Z/B register.
- Holds FLAG_W flags. Each flag is either level (follows ALU) or sticky (OR-accumulates until explicitly cleared), selected per bit by parameter.
- Per-instruction write mask.
- Adds a save/restore LIFO of depth STACK_DEPTH for interrupt/call context, with full/empty status and a sticky error flag.
- Sits between the ALU flag outputs and the control unit / branch logic.

Parameters:
FLAG_W, 4, number of flags; bit0=C, bit1=Z, bit2=B, bit3=N.
STACK_DEPTH, 4, number of saved flag words, >=1.
STICKY_MASK, 4'b0101, per-flag mode; 1 = sticky, 0 = level.
LVL_W, 3, width of stk_level, >= clog2(STACK_DEPTH+1).

Ports:
clk  in  1  system clock; all state updates on rising edge.
flag_rst_n  in  1  synchronous active-low reset.
flag_we  in  1  apply ALU flags this cycle.
flag_mask  in  FLAG_W  flags affected by current instruction; ignored when flag_we=0.
flag_in  in  FLAG_W  new flag values from ALU.
flag_clr  in  FLAG_W  explicit per-flag clear.
flag_push  in  1  save current flag_out to stack.
flag_pop  in  1  restore flag_out from stack top.
err_clr  in  1  clear stk_err.
flag_out  out  FLAG_W  registered flag state.
stk_full  out  1  level == STACK_DEPTH.
stk_empty  out  1  level == 0.
stk_level  out  LVL_W  number of saved entries.
stk_err  out  1  sticky error: overflow, underflow or push+pop collision.

Behaviour:
Reset and latency
- Reset (flag_rst_n=0 at posedge): flag_out=0, stk_level=0, stk_err=0, stk_empty=1, stk_full=0. Stack contents are don't-care.
- Reset has priority over every other input.
- All outputs are registered. Effects become visible one cycle after the sampling edge.
- stk_full and stk_empty decode from the registered stk_level.

Per-bit flag update (no pop in effect)
- If flag_clr[i]: flag_out[i]<=0. Clear wins over any set in the same cycle.
- Else if flag_we and flag_mask[i] and STICKY_MASK[i]: flag_out[i] <= flag_out[i] | flag_in[i].
- Else if flag_we and flag_mask[i] and !STICKY_MASK[i]: flag_out[i] <= flag_in[i].
- Else hold.

Push only
- If !stk_full: stack[level] <= flag_out (the pre-update value), level+1. The flag update above applies in the same cycle.
- If stk_full: stack and level unchanged, stk_err<=1, flag update still applies.

Pop only
- If !stk_empty: flag_out <= stack[level-1], level-1. flag_we and flag_clr are ignored that cycle.
- If stk_empty: level unchanged, stk_err<=1, normal flag update applies.

Push and pop in the same cycle
- No stack operation, level unchanged, stk_err<=1.
- Normal flag update applies.

stk_err
- Set by any error above; set wins over err_clr in the same cycle.
- Otherwise err_clr clears it.

Stack storage
- Register array, no wrap-around.
- Level saturates at 0 and STACK_DEPTH.

Optional Feature:
Macro FLAG_PUSH_AUTOCLR_EN.
- Defined: a successful push also clears flag_out to 0 in the same cycle, overriding flag_we/flag_in, so the handler starts with clean flags. Failed pushes (full or collision) do not clear.
- Undefined: push leaves flag_out subject only to the normal update rules.

Test Plan:
1. Reset and level/sticky update: hold flag_rst_n=0 two cycles -> flag_out=0, stk_empty=1, stk_level=0. Then flag_we=1, mask=4'hF, in=4'b0001 -> out=4'b0001. Then in=4'b0000 -> out=4'b0001 (C sticky). Then flag_clr=4'b0001 -> out=4'b0000.
2. Level flag and clear-vs-set: in=4'b0010 then in=4'b0000 -> Z follows, 1 then 0. flag_clr=4'b0100 with flag_we, in=4'b0100 same cycle -> B=0 (clear wins).
3. Mask: out=4'b1010, then flag_we, mask=4'b0010, in=4'b0000 -> out=4'b1000.
4. Push/pop: push 4'hA, 4'h5, 4'h3, 4'hC -> stk_full=1, level=4. Fifth push -> stk_err=1, level=4. Four pops -> out sequence 4'hC, 4'h3, 4'h5, 4'hA, stk_empty=1. Fifth pop -> out unchanged.
5. Collision and error clear: push+pop same cycle at level=2 -> level=2, stk_err=1. err_clr -> stk_err=0. err_clr coincident with an underflow -> stk_err stays 1.
6. Reset mid-operation and optional feature: level=3, out=4'h7, assert flag_rst_n=0 together with pop -> out=0, level=0, stk_err=0. With FLAG_PUSH_AUTOCLR_EN defined, push at out=4'hF -> stack top=4'hF, out=0.
